// File: rtl/freq_flag_detector_pkg.sv
// Shared types, flag levels and the window classifier for the frequency flag detector.
package freq_flag_pkg;

    localparam int FLAG_W = 3;

    typedef enum logic [1:0] {
        SGN_UNK = 2'd0,
        SGN_POS = 2'd1,
        SGN_NEG = 2'd2
    } sign_state_t;

    localparam logic [FLAG_W-1:0] FLAG_L0 = 3'd0;
    localparam logic [FLAG_W-1:0] FLAG_L1 = 3'd1;
    localparam logic [FLAG_W-1:0] FLAG_L2 = 3'd2;
    localparam logic [FLAG_W-1:0] FLAG_L3 = 3'd3;
    localparam logic [FLAG_W-1:0] FLAG_L4 = 3'd4;

    // Quiet windows always map to level 0 regardless of crossing count.
    function automatic logic [FLAG_W-1:0] classify(
        input logic [31:0] count,
        input logic        peak_ok,
        input logic [31:0] th1,
        input logic [31:0] th2,
        input logic [31:0] th3,
        input logic [31:0] th4
    );
        logic [FLAG_W-1:0] lvl;
        if (!peak_ok) begin
            lvl = FLAG_L0;
        end else if (count < th1) begin
            lvl = FLAG_L0;
        end else if (count < th2) begin
            lvl = FLAG_L1;
        end else if (count < th3) begin
            lvl = FLAG_L2;
        end else if (count < th4) begin
            lvl = FLAG_L3;
        end else begin
            lvl = FLAG_L4;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/freq_flag_detector_if.sv
// Audio sample stream in, frequency flag out.
interface freq_flag_detector_if #(
    parameter int SAMPLE_W = 16
);
    logic signed [SAMPLE_W-1:0]            audio_in;
    logic                                  audio_valid;
    logic [freq_flag_pkg::FLAG_W-1:0]      freq_flag;
    logic                                  flag_valid;

    modport master (output audio_in, output audio_valid, input freq_flag, input flag_valid);
    modport slave  (input audio_in, input audio_valid, output freq_flag, output flag_valid);
endinterface

// File: rtl/freq_flag_detector_zero_cross_detector.sv
// Sign tracker with a dead band; flags a crossing on the edge that accepts the causing sample.
module zero_cross_detector
    import freq_flag_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ZC_HYST  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       valid_i,
    output logic                       crossing_o
);

    localparam logic signed [SAMPLE_W:0] HYST_POS = (SAMPLE_W+1)'(ZC_HYST);
    localparam logic signed [SAMPLE_W:0] HYST_NEG = -HYST_POS;

    sign_state_t               sign_q, sign_d;
    logic signed [SAMPLE_W:0]  sample_ext_s;
    logic                      above_s, below_s;

    assign sample_ext_s = {sample_i[SAMPLE_W-1], sample_i};
    assign above_s      = sample_ext_s > HYST_POS;
    assign below_s      = sample_ext_s < HYST_NEG;

    // Sign state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= SGN_UNK;
        end else begin
            sign_q <= sign_d;
        end
    end

    // In-band samples hold the state; only a POS<->NEG flip is a crossing.
    always_comb begin
        sign_d     = sign_q;
        crossing_o = 1'b0;
        if (valid_i && above_s) begin
            sign_d     = SGN_POS;
            crossing_o = (sign_q == SGN_NEG);
        end else if (valid_i && below_s) begin
            sign_d     = SGN_NEG;
            crossing_o = (sign_q == SGN_POS);
        end else begin
            sign_d     = sign_q;
        end
    end

endmodule

// File: rtl/freq_flag_detector.sv
// Windowed zero-crossing counter with noise gate, level classifier and two-window hysteresis.
module freq_flag_detector
    import freq_flag_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int WINDOW      = 1024,
    parameter int ZC_HYST     = 64,
    parameter int NOISE_FLOOR = 256,
    parameter int TH1         = 8,
    parameter int TH2         = 16,
    parameter int TH3         = 32,
    parameter int TH4         = 64
) (
    input  logic clk,
    input  logic rst_n,
    freq_flag_detector_if.slave bus
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [SAMPLE_W-1:0] MAX_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] MIN_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [CW-1:0]       CNT_MAX = {CW{1'b1}};

    logic [CW-1:0]       samp_cnt_q, samp_cnt_d;
    logic [CW-1:0]       cross_cnt_q, cross_cnt_d;
    logic [CW-1:0]       cnt_snap_q, cnt_snap_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic                peak_ok_q, peak_ok_d;
    logic                close_q, close_d;
    logic [FLAG_W-1:0]   flag_q, flag_d;
    logic [FLAG_W-1:0]   cand_q, cand_d;
    logic                flag_valid_q, flag_valid_d;

    logic                crossing_s;
    logic [SAMPLE_W-1:0] abs_s;
    logic [SAMPLE_W-1:0] peak_new_s;
    logic [CW-1:0]       cross_new_s;
    logic [FLAG_W-1:0]   class_s;

    zero_cross_detector #(
        .SAMPLE_W (SAMPLE_W),
        .ZC_HYST  (ZC_HYST)
    ) u_zcd (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_i   (bus.audio_in),
        .valid_i    (bus.audio_valid),
        .crossing_o (crossing_s)
    );

    // Magnitude of the incoming sample; the most negative code saturates.
    always_comb begin
        abs_s = bus.audio_in;
        if (bus.audio_in == MIN_NEG) begin
            abs_s = MAX_POS;
        end else if (bus.audio_in[SAMPLE_W-1]) begin
            abs_s = -bus.audio_in;
        end else begin
            abs_s = bus.audio_in;
        end
    end

    assign peak_new_s  = (abs_s > peak_q) ? abs_s : peak_q;
    assign cross_new_s = (crossing_s && (cross_cnt_q != CNT_MAX)) ? cross_cnt_q + CW'(1) : cross_cnt_q;

    // Window accumulation; the closing sample is folded into the snapshot taken at close.
    always_comb begin
        samp_cnt_d  = samp_cnt_q;
        cross_cnt_d = cross_cnt_q;
        peak_d      = peak_q;
        cnt_snap_d  = cnt_snap_q;
        peak_ok_d   = peak_ok_q;
        close_d     = 1'b0;
        if (bus.audio_valid && (samp_cnt_q == CW'(WINDOW - 1))) begin
            samp_cnt_d  = '0;
            cross_cnt_d = '0;
            peak_d      = '0;
            cnt_snap_d  = cross_new_s;
            peak_ok_d   = 32'(peak_new_s) >= 32'(NOISE_FLOOR);
            close_d     = 1'b1;
        end else if (bus.audio_valid) begin
            samp_cnt_d  = samp_cnt_q + CW'(1);
            cross_cnt_d = cross_new_s;
            peak_d      = peak_new_s;
        end else begin
            samp_cnt_d  = samp_cnt_q;
        end
    end

    assign class_s = classify(32'(cnt_snap_q), peak_ok_q, 32'(TH1), 32'(TH2), 32'(TH3), 32'(TH4));

    // Hysteresis: a new level is only adopted when it repeats the previous candidate.
    always_comb begin
        flag_d       = flag_q;
        cand_d       = cand_q;
        flag_valid_d = close_q;
        if (close_q && (class_s == flag_q)) begin
            cand_d = flag_q;
        end else if (close_q && (class_s == cand_q)) begin
            flag_d = class_s;
        end else if (close_q) begin
            cand_d = class_s;
        end else begin
            flag_d = flag_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_q   <= '0;
            cross_cnt_q  <= '0;
            peak_q       <= '0;
            cnt_snap_q   <= '0;
            peak_ok_q    <= 1'b0;
            close_q      <= 1'b0;
            flag_q       <= FLAG_L0;
            cand_q       <= FLAG_L0;
            flag_valid_q <= 1'b0;
        end else begin
            samp_cnt_q   <= samp_cnt_d;
            cross_cnt_q  <= cross_cnt_d;
            peak_q       <= peak_d;
            cnt_snap_q   <= cnt_snap_d;
            peak_ok_q    <= peak_ok_d;
            close_q      <= close_d;
            flag_q       <= flag_d;
            cand_q       <= cand_d;
            flag_valid_q <= flag_valid_d;
        end
    end

    assign bus.freq_flag  = flag_q;
    assign bus.flag_valid = flag_valid_q;

endmodule

// File: tb/tb_freq_flag_detector.sv
// Directed window-by-window bench for freq_flag_detector with small-window parameters.
module tb_freq_flag_detector;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    freq_flag_detector_if #(.SAMPLE_W(16)) bus_if ();

    freq_flag_detector #(
        .SAMPLE_W    (16),
        .WINDOW      (16),
        .ZC_HYST     (100),
        .NOISE_FLOOR (500),
        .TH1         (2),
        .TH2         (4),
        .TH3         (8),
        .TH4         (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        int         a;
        int         b;
        int         period;
        logic [2:0] exp_flag;
    } win_t;

    win_t tbl [18];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Sixteen contiguous samples, then idle; pulse expected one cycle after the 16th.
    task automatic run_window(input win_t w, input string nm);
        int early;
        early = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus_if.flag_valid !== 1'b0) early++;
            bus_if.audio_valid = 1'b1;
            bus_if.audio_in    = (((i / w.period) % 2) == 0) ? 16'(w.a) : 16'(w.b);
        end
        @(negedge clk);
        if (bus_if.flag_valid !== 1'b0) early++;
        bus_if.audio_valid = 1'b0;
        @(negedge clk);
        check({nm, "_no_early_pulse"}, early, 0);
        check({nm, "_flag_valid"}, 32'(bus_if.flag_valid), 1);
        check({nm, "_freq_flag"}, 32'(bus_if.freq_flag), 32'(w.exp_flag));
    endtask

    initial begin
        int   stray;
        win_t w;
        n_cmp  = 0;
        n_fail = 0;

        tbl[0]  = '{1000, -1000, 1, 3'd0};
        tbl[1]  = '{1000, -1000, 1, 3'd4};
        tbl[2]  = '{-1000, 1000, 1, 3'd4};
        tbl[3]  = '{1000, -1000, 8, 3'd4};
        tbl[4]  = '{1000, -1000, 1, 3'd4};
        tbl[5]  = '{300, -300, 1, 3'd4};
        tbl[6]  = '{300, -300, 1, 3'd0};
        tbl[7]  = '{300, -300, 1, 3'd0};
        tbl[8]  = '{300, -300, 1, 3'd0};
        tbl[9]  = '{1000, -50, 1, 3'd0};
        tbl[10] = '{1000, -1000, 4, 3'd0};
        tbl[11] = '{-1000, 1000, 4, 3'd1};
        tbl[12] = '{1000, -1000, 2, 3'd1};
        tbl[13] = '{-1000, 1000, 2, 3'd2};
        tbl[14] = '{-1000, 1000, 8, 3'd2};
        tbl[15] = '{-1000, 1000, 8, 3'd1};
        tbl[16] = '{-32768, 200, 1, 3'd1};
        tbl[17] = '{-32768, 200, 1, 3'd4};

        rst_n              = 1'b0;
        bus_if.audio_valid = 1'b0;
        bus_if.audio_in    = 16'sd0;
        repeat (3) @(negedge clk);
        check("reset_flag_valid", 32'(bus_if.flag_valid), 0);
        check("reset_freq_flag", 32'(bus_if.freq_flag), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_flag_valid", 32'(bus_if.flag_valid), 0);
        check("post_reset_freq_flag", 32'(bus_if.freq_flag), 0);

        for (int k = 0; k < 18; k++) begin
            run_window(tbl[k], $sformatf("win%0d", k));
        end

        // Partial window with gaps and the most negative code, then reset mid-window.
        stray = 0;
        for (int j = 0; j < 10; j++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                if (bus_if.flag_valid !== 1'b0) stray++;
                bus_if.audio_valid = 1'b0;
            end
            @(negedge clk);
            if (bus_if.flag_valid !== 1'b0) stray++;
            bus_if.audio_valid = 1'b1;
            bus_if.audio_in    = (j == 4) ? -16'sd32768 : (((j % 2) == 0) ? 16'sd1000 : -16'sd1000);
        end
        @(negedge clk);
        if (bus_if.flag_valid !== 1'b0) stray++;
        bus_if.audio_valid = 1'b0;
        check("partial_no_pulse", stray, 0);
        check("pre_reset_freq_flag", 32'(bus_if.freq_flag), 4);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_freq_flag", 32'(bus_if.freq_flag), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        w = '{1000, -1000, 1, 3'd0};
        run_window(w, "after_reset_win0");
        w = '{-1000, 1000, 1, 3'd4};
        run_window(w, "after_reset_win1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
